// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// State encodings, default width and counter sizing.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
// The requester drives start and operands; the subtractor drives status and result.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out, overflow
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out, overflow
    );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, WIDTH cycles per result.
// Results are held in output registers until the next operation completes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [WIDTH-1:0] diff_q;
    logic             a_msb;
    logic             b_msb;
    logic             borrow;
    logic             borrow_q;
    logic             ovf_q;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             bout;
    logic             last;

    full_subtractor u_cell (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .bin (borrow),
        .d   (d),
        .bout(bout)
    );

    assign last   = (cnt == LAST);
    assign res_nx = {d, {(WIDTH-1){1'b0}}} | (res >> 1);

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = bus.start ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = bus.start ? RUN : IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res      <= '0;
            diff_q   <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            borrow   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            state <= next;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        a_msb  <= bus.a[WIDTH-1];
                        b_msb  <= bus.b[WIDTH-1];
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res    <= res_nx;
                    borrow <= bout;
                    cnt    <= cnt + 1'b1;
                    // The MSB of the result is the bit produced on this last edge.
                    if (last) begin
                        diff_q   <= res_nx;
                        borrow_q <= bout;
                        ovf_q    <= (a_msb != b_msb) && (d != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state == RUN);
    assign bus.done       = (state == DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done diff=%h", bus.diff);
            end else begin
                e = sb.pop_front();
                checks += 3;
                if (bus.diff !== e.diff) begin
                    errors++;
                    $display("FAIL diff got=%h exp=%h", bus.diff, e.diff);
                end
                if (bus.borrow_out !== e.borrow) begin
                    errors++;
                    $display("FAIL borrow_out got=%b exp=%b", bus.borrow_out, e.borrow);
                end
                if (bus.overflow !== e.ovf) begin
                    errors++;
                    $display("FAIL overflow got=%b exp=%b", bus.overflow, e.ovf);
                end
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t x;
        x.diff   = a - b;
        x.borrow = (a < b);
        x.ovf    = (a[W-1] != b[W-1]) && (x.diff[W-1] != a[W-1]);
        sb.push_back(x);
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        if (push) push_exp(a, b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int poke, output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (cycles == poke) begin
                bus.start = 1'b1;
                bus.a     = 8'hFF;
                bus.b     = 8'h01;
            end else if (cycles == poke + 1) begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'h01;
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        if (bus.diff !== 8'h00) begin
            errors++;
            $display("FAIL reset_diff got=%h exp=00", bus.diff);
        end
        if (bus.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_borrow got=%b exp=0", bus.borrow_out);
        end
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_overflow got=%b exp=0", bus.overflow);
        end
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_patterns();
        logic [W-1:0] ta[8];
        logic [W-1:0] tb[8];
        logic [W-1:0] prev;
        int cyc;
        int bcnt;
        ta = '{8'h35, 8'h12, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h00, 8'h01};
        tb = '{8'h12, 8'h35, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h80};
        prev = 8'h00;
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = (i < 8) ? ta[i] : W'($urandom);
            b = (i < 8) ? tb[i] : W'($urandom);
            launch(a, b, 1'b1);
            checks++;
            if (bus.diff !== prev) begin
                errors++;
                $display("FAIL hold_diff got=%h exp=%h", bus.diff, prev);
            end
            wait_done(-1, cyc, bcnt);
            checks += 3;
            if (cyc !== W) begin
                errors++;
                $display("FAIL latency got=%0d exp=%0d", cyc, W);
            end
            if (bcnt !== W) begin
                errors++;
                $display("FAIL busy_cycles got=%0d exp=%0d", bcnt, W);
            end
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_done got=%b exp=0", bus.busy);
            end
            prev = a - b;
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got=%b exp=0", bus.done);
            end
        end
    endtask

    task automatic test_mid_start();
        int cyc;
        int bcnt;
        launch(8'h35, 8'h12, 1'b1);
        wait_done(3, cyc, bcnt);
        checks += 2;
        if (cyc !== W) begin
            errors++;
            $display("FAIL mid_start_latency got=%0d exp=%0d", cyc, W);
        end
        if (bcnt !== W) begin
            errors++;
            $display("FAIL mid_start_busy got=%0d exp=%0d", bcnt, W);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int  n;
        int  ndone;
        int  last;
        int  want;
        bit  prev;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        for (int i = 0; i < 3; i++) push_exp(8'h10, 8'h01);
        n     = 0;
        ndone = 0;
        last  = 0;
        prev  = 1'b0;
        while (ndone < 3 && n < 60) begin
            @(negedge clk);
            n++;
            if (prev) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_no_idle got=%b exp=1", bus.busy);
                end
            end
            prev = 1'b0;
            if (bus.done === 1'b1) begin
                ndone++;
                want = (ndone == 1) ? W + 1 : last + W + 1;
                checks++;
                if (n !== want) begin
                    errors++;
                    $display("FAIL b2b_period got=%0d exp=%0d", n, want);
                end
                last = n;
                prev = (ndone < 3);
                if (ndone == 3) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (ndone !== 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d exp=3", ndone);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got=%b%b exp=00", bus.busy, bus.done);
        end
    endtask

    task automatic test_reset_abort();
        int cyc;
        int bcnt;
        launch(8'h35, 8'h12, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy got=%b exp=0", bus.busy);
        end
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_done got=%b exp=0", bus.done);
        end
        if (bus.diff !== 8'h00) begin
            errors++;
            $display("FAIL abort_diff got=%h exp=00", bus.diff);
        end
        if (bus.borrow_out !== 1'b0) begin
            errors++;
            $display("FAIL abort_borrow got=%b exp=0", bus.borrow_out);
        end
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL abort_overflow got=%b exp=0", bus.overflow);
        end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        launch(8'h0A, 8'h03, 1'b1);
        wait_done(-1, cyc, bcnt);
        checks++;
        if (cyc !== W) begin
            errors++;
            $display("FAIL post_reset_latency got=%0d exp=%0d", cyc, W);
        end
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_patterns();
        test_mid_start();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
